// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory controller for the CPU MEM stage.
//
// Word-addressed RAM with byte-lane stores (word/half/byte) and registered,
// sign- or zero-extended loads. Reset zeroes the RAM one word per cycle
// through a CLEAR state; requests are taken only while ready is high.
//
// Ports:
//   Clk       clock, rising edge
//   reset     synchronous active-high reset (restarts the clear sweep)
//   req       access request, accepted when req && ready
//   MemWrite  1 = store, 0 = load
//   MemAddr   byte address
//   Memdata   right-aligned store data
//   dmCon     [1:0] size (0 word, 1 half, 2 byte, 3 reserved), [2] zero-extend
//   ready     high in IDLE
//   rvalid    one-cycle load response pulse
//   Memout    extended load data, held until the next load response
//   err       one-cycle fault pulse in the response cycle
//
// Build option: define DM_TRACE_EN to print committed stores and faults.

module dm_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [31:0] MemAddr,
  input  logic [31:0] Memdata,
  input  logic [2:0]  dmCon,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] Memout,
  output logic        err
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [31:0]    mem [DEPTH];

  logic [1:0]     size_c;
  logic           in_range_c;
  logic           fault_c;
  logic           accept_c;
  logic [AW-1:0]  idx_c;
  logic [3:0]     be_sel_c;
  logic [31:0]    wdata_sel_c;
  logic [31:0]    rdata_c;
  logic [31:0]    ext_c;

  logic           we_c;
  logic [3:0]     be_c;
  logic [AW-1:0]  widx_c;
  logic [31:0]    wdata_c;

  // Address decode: range, alignment, lane enables, replicated store data.
  always_comb begin
    size_c      = dmCon[1:0];
    idx_c       = MemAddr[AW+1:2];
    in_range_c  = (MemAddr[31:AW+2] == BASE_ADDR[31:AW+2]);
    accept_c    = req && ready;
    fault_c     = !in_range_c;
    be_sel_c    = 4'b0000;
    wdata_sel_c = Memdata;
    case (size_c)
      2'd0: begin
        fault_c  = fault_c || (MemAddr[1:0] != 2'b00);
        be_sel_c = 4'b1111;
      end
      2'd1: begin
        fault_c     = fault_c || MemAddr[0];
        be_sel_c    = MemAddr[1] ? 4'b1100 : 4'b0011;
        wdata_sel_c = {2{Memdata[15:0]}};
      end
      2'd2: begin
        be_sel_c    = 4'b0001 << MemAddr[1:0];
        wdata_sel_c = {4{Memdata[7:0]}};
      end
      default: fault_c = 1'b1;
    endcase
  end

  // Load lane select and extension; word loads ignore the zero-extend bit.
  always_comb begin
    logic [15:0] half;
    logic [7:0]  byte_v;
    rdata_c = mem[idx_c];
    half    = MemAddr[1] ? rdata_c[31:16] : rdata_c[15:0];
    case (MemAddr[1:0])
      2'd0:    byte_v = rdata_c[7:0];
      2'd1:    byte_v = rdata_c[15:8];
      2'd2:    byte_v = rdata_c[23:16];
      default: byte_v = rdata_c[31:24];
    endcase
    case (size_c)
      2'd1:    ext_c = {{16{~dmCon[2] & half[15]}}, half};
      2'd2:    ext_c = {{24{~dmCon[2] & byte_v[7]}}, byte_v};
      default: ext_c = rdata_c;
    endcase
  end

  // Next state and RAM write port: clear sweep or committed store.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_c    = 1'b0;
    be_c    = 4'b0000;
    widx_c  = idx_c;
    wdata_c = 32'h0;
    case (state_q)
      S_CLEAR: begin
        we_c   = 1'b1;
        be_c   = 4'b1111;
        widx_c = cnt_q;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept_c && MemWrite && !fault_c) begin
          we_c    = 1'b1;
          be_c    = be_sel_c;
          wdata_c = wdata_sel_c;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // State, clear counter and registered outputs.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      Memout  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= (state_d == S_IDLE);
      rvalid  <= accept_c && !MemWrite;
      err     <= accept_c && fault_c;
      if (accept_c && !MemWrite) Memout <= fault_c ? 32'h0 : ext_c;
    end
  end

  // RAM array; no reset, contents are zeroed by the clear sweep.
  always_ff @(posedge Clk) begin
    if (we_c && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[widx_c][8*b +: 8] <= wdata_c[8*b +: 8];
      end
    end
  end

`ifdef DM_TRACE_EN
  // Store / fault trace.
  always_ff @(posedge Clk) begin
    if (!reset && accept_c) begin
      if (fault_c) begin
        $display("dm error @%08h", MemAddr);
      end else if (MemWrite) begin
        case (size_c)
          2'd0:    $display("*%08h <= %08h", MemAddr, Memdata);
          2'd1:    $display("*%08h <= %04h", MemAddr, Memdata[15:0]);
          default: $display("*%08h <= %02h", MemAddr, Memdata[7:0]);
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed testbench for dm_ctrl (default parameters: 2048 words at base 0).
module tb_dm_ctrl;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] MemAddr = 32'h0;
  logic [31:0] Memdata = 32'h0;
  logic [2:0]  dmCon = 3'b000;
  logic        ready;
  logic        rvalid;
  logic [31:0] Memout;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // dmCon encodings
  localparam logic [2:0] W   = 3'b000;
  localparam logic [2:0] HS  = 3'b001;
  localparam logic [2:0] BS  = 3'b010;
  localparam logic [2:0] RSV = 3'b011;
  localparam logic [2:0] HU  = 3'b101;
  localparam logic [2:0] BU  = 3'b110;

  dm_ctrl dut (
    .Clk      (Clk),
    .reset    (reset),
    .req      (req),
    .MemWrite (MemWrite),
    .MemAddr  (MemAddr),
    .Memdata  (Memdata),
    .dmCon    (dmCon),
    .ready    (ready),
    .rvalid   (rvalid),
    .Memout   (Memout),
    .err      (err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One request cycle; returns #1 after the accepting edge (response cycle).
  task automatic acc(input logic we, input logic [31:0] addr, input logic [31:0] data,
                     input logic [2:0] con);
    @(negedge Clk);
    req = 1'b1; MemWrite = we; MemAddr = addr; Memdata = data; dmCon = con;
    @(posedge Clk); #1;
    req = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input logic [2:0] con,
                    input logic [31:0] exp);
    acc(1'b0, addr, 32'h0, con);
    check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    check({tag, ".err"}, 32'(err), 32'd0);
    check({tag, ".data"}, Memout, exp);
  endtask

  task automatic ld_fault(input string tag, input logic [31:0] addr, input logic [2:0] con);
    acc(1'b0, addr, 32'h0, con);
    check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    check({tag, ".err"}, 32'(err), 32'd1);
    check({tag, ".data"}, Memout, 32'h0);
  endtask

  task automatic st(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [2:0] con, input logic exp_err);
    acc(1'b1, addr, data, con);
    check({tag, ".rvalid"}, 32'(rvalid), 32'd0);
    check({tag, ".err"}, 32'(err), 32'(exp_err));
  endtask

  // Counts edges after reset release until ready rises (bounded).
  task automatic count_clear(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (!ready && n < 5000);
    check(tag, 32'(n), 32'd2048);
  endtask

  initial begin
    logic seen;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.rvalid", 32'(rvalid), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.Memout", Memout, 32'h0);
    @(negedge Clk) reset = 1'b0;
    count_clear("clear.len");

    ld("ld7fc", 32'h7FC, W, 32'h0);

    // Word store, signed byte read of the top lane
    st("st10", 32'h10, 32'h1234_5678, W, 1'b0);
    ld("ldb13", 32'h13, BS, 32'h0000_0012);
    @(posedge Clk); #1;
    check("ldb13.pulse", 32'(rvalid), 32'd0);
    check("ldb13.hold", Memout, 32'h0000_0012);

    // Half store into upper half of a zero word
    st("st20", 32'h20, 32'h0, W, 1'b0);
    st("sth22", 32'h22, 32'hDEAD_BEEF, HS, 1'b0);
    ld("ldw20", 32'h20, W, 32'hBEEF_0000);
    ld("ldh22s", 32'h22, HS, 32'hFFFF_BEEF);
    ld("ldh22u", 32'h22, HU, 32'h0000_BEEF);
    ld("ldh20", 32'h20, HS, 32'h0);

    // Byte store then immediate reads
    st("stb31", 32'h31, 32'h0000_0080, BS, 1'b0);
    ld("ldb31s", 32'h31, BS, 32'hFFFF_FF80);
    ld("ldb31u", 32'h31, BU, 32'h0000_0080);
    ld("ldw30", 32'h30, W, 32'h0000_8000);

    // Byte lane 3 with garbage upper data bits
    st("stb13", 32'h13, 32'hFFFF_FFAB, BS, 1'b0);
    ld("ldw10a", 32'h10, W, 32'hAB34_5678);
    st("st10b", 32'h10, 32'h1234_5678, W, 1'b0);

    // Faults
    ld_fault("fld6", 32'h6, W);
    @(posedge Clk); #1;
    check("fld6.errpulse", 32'(err), 32'd0);
    st("fsth5", 32'h5, 32'h0000_AAAA, HS, 1'b1);
    ld("rb4", 32'h4, W, 32'h0);
    ld_fault("fld2000", 32'h2000, W);
    ld_fault("fldrsv", 32'h10, RSV);
    st("fstrsv", 32'h10, 32'hFFFF_FFFF, RSV, 1'b1);
    st("fst2010", 32'h2010, 32'hCAFE_F00D, W, 1'b1);
    st("fstw12", 32'h12, 32'hCAFE_F00D, W, 1'b1);
    ld("rb10", 32'h10, W, 32'h1234_5678);

    // Reset together with a request: no response
    @(negedge Clk);
    reset = 1'b1; req = 1'b1; MemWrite = 1'b0; MemAddr = 32'h2000; dmCon = W;
    @(posedge Clk); #1;
    check("rstreq.rvalid", 32'(rvalid), 32'd0);
    check("rstreq.err", 32'(err), 32'd0);
    check("rstreq.ready", 32'(ready), 32'd0);

    // Requests during CLEAR are ignored; reset at cycle 100 restarts the sweep
    @(negedge Clk) reset = 1'b0;
    MemAddr = 32'h10;
    seen = 1'b0;
    repeat (100) begin
      @(posedge Clk); #1;
      if (rvalid || err || ready) seen = 1'b1;
    end
    check("clr.noresp", 32'(seen), 32'd0);
    @(negedge Clk) reset = 1'b1;
    @(negedge Clk) reset = 1'b0;
    req = 1'b0;
    count_clear("clear.restart");
    ld("clr.rb10", 32'h10, W, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
